// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the clocking/reset fabric:
// lock flags in, PLL reset, staged domain resets and status counters out.
interface pll_reset_sequencer_if #(
    parameter int unsigned NUM_STAGES = 3
);
    logic                  pll_main_lock;
    logic                  pll_ram_lock;
    logic                  pll_rst;
    logic [NUM_STAGES-1:0] rst_out;
    logic                  all_up;
    logic [7:0]            relock_count;
    logic [7:0]            timeout_count;

    modport master (
        input  pll_main_lock,
        input  pll_ram_lock,
        output pll_rst,
        output rst_out,
        output all_up,
        output relock_count,
        output timeout_count
    );

    modport slave (
        output pll_main_lock,
        output pll_ram_lock,
        input  pll_rst,
        input  rst_out,
        input  all_up,
        input  relock_count,
        input  timeout_count
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL lock watchdog and staged reset generator. Runs on the free-running
// reference clock, pulses the PLL reset and releases domain resets in order.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned NUM_STAGES          = 3,
    parameter int unsigned STAGE_GAP           = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    pll_reset_sequencer_if.master  bus
);

    localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_B   = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABILIZE,
        RELEASE,
        RUN
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            main_sync_q;
    logic [1:0]            ram_sync_q;
    logic                  lock_ok;
    logic                  pll_rst_q, pll_rst_d;
    logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
    logic [NUM_STAGES-1:0] rst_out_shifted;
    logic                  all_up_q, all_up_d;
    logic [7:0]            relock_q, relock_d;
    logic [7:0]            timeout_q, timeout_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign lock_ok = main_sync_q[1] & ram_sync_q[1];

    // Bit 0 is released first, so each stage release is a left shift of the
    // thermometer code; the last release leaves the vector all zero.
    assign rst_out_shifted = rst_out_q << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            main_sync_q <= '0;
            ram_sync_q  <= '0;
            pll_rst_q   <= 1'b1;
            rst_out_q   <= '1;
            all_up_q    <= 1'b0;
            relock_q    <= '0;
            timeout_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            main_sync_q <= {main_sync_q[0], bus.pll_main_lock};
            ram_sync_q  <= {ram_sync_q[0], bus.pll_ram_lock};
            pll_rst_q   <= pll_rst_d;
            rst_out_q   <= rst_out_d;
            all_up_q    <= all_up_d;
            relock_q    <= relock_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        rst_out_d = rst_out_q;
        relock_d  = relock_q;
        timeout_d = timeout_q;

        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // Lock is checked first so a simultaneous expiry is not counted.
                if (lock_ok) begin
                    state_d = STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = RESET_PLL;
                    timeout_d = sat_inc(timeout_q);
                end
            end
            STABILIZE: begin
                if (!lock_ok) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    rst_out_d = rst_out_shifted;
                    state_d   = (rst_out_shifted == '0) ? RUN : RELEASE;
                end
            end
            RELEASE: begin
                if (!lock_ok) begin
                    state_d  = RESET_PLL;
                    relock_d = sat_inc(relock_q);
                end else if (cnt_q == GAP_LAST) begin
                    rst_out_d = rst_out_shifted;
                    cnt_d     = '0;
                    if (rst_out_shifted == '0) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_ok) begin
                    state_d  = RESET_PLL;
                    relock_d = sat_inc(relock_q);
                end
            end
            default: begin
                state_d = RESET_PLL;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Outputs are registered from the next state so they change on the
        // same edge as the transition that causes them.
        if (state_d inside {RESET_PLL, WAIT_LOCK, STABILIZE}) begin
            rst_out_d = '1;
        end
        pll_rst_d = (state_d == RESET_PLL);
        all_up_d  = (state_d == RUN);
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.rst_out       = rst_out_q;
    assign bus.all_up        = all_up_q;
    assign bus.relock_count  = relock_q;
    assign bus.timeout_count = timeout_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: each scenario queues a per-cycle
// expected output vector, a negedge monitor pops and compares against the DUT.
module tb_pll_reset_sequencer;

    localparam int unsigned NS = 3;

    logic clk = 1'b0;
    logic rst;

    always #4 clk = ~clk;

    pll_reset_sequencer_if #(.NUM_STAGES(NS)) bus ();

    pll_reset_sequencer #(
        .PLL_RST_CYCLES      (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .LOCK_STABLE_CYCLES  (8),
        .NUM_STAGES          (NS),
        .STAGE_GAP           (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        int          scen;
        int          t;
        logic        pll_rst;
        logic [2:0]  rst_out;
        logic        all_up;
        logic [7:0]  relock;
        logic [7:0]  tmo;
    } exp_t;

    exp_t exp_q[$];
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs after edge e0+t, where e0 is the last edge sampling rst high.
    function automatic exp_t mk(input int scen, input int e0, input int t);
        exp_t e;
        int   k;
        e.cyc     = e0 + t;
        e.scen    = scen;
        e.t       = t;
        e.pll_rst = 1'b0;
        e.rst_out = 3'b111;
        e.relock  = 8'd0;
        e.tmo     = 8'd0;
        case (scen)
            1: begin
                // Bring-up, loss in RUN, loss mid-RELEASE, one timeout, rst mid-RUN
                e.pll_rst = (t <= 3) || (t >= 52 && t <= 55) || (t >= 102 && t <= 105) ||
                            (t >= 123 && t <= 126) || (t >= 159 && t <= 162) ||
                            (t >= 200 && t <= 203);
                if (t >= 200)      e.relock = 8'd0;
                else if (t >= 123) e.relock = 8'd3;
                else if (t >= 102) e.relock = 8'd2;
                else if (t >= 52)  e.relock = 8'd1;
                e.tmo = (t >= 159 && t < 200) ? 8'd1 : 8'd0;
                if      (t >= 30  && t <= 33)  e.rst_out = 3'b110;
                else if (t >= 34  && t <= 37)  e.rst_out = 3'b100;
                else if (t >= 38  && t <= 51)  e.rst_out = 3'b000;
                else if (t >= 80  && t <= 83)  e.rst_out = 3'b110;
                else if (t >= 84  && t <= 87)  e.rst_out = 3'b100;
                else if (t >= 88  && t <= 101) e.rst_out = 3'b000;
                else if (t >= 120 && t <= 122) e.rst_out = 3'b110;
                else if (t >= 180 && t <= 183) e.rst_out = 3'b110;
                else if (t >= 184 && t <= 187) e.rst_out = 3'b100;
                else if (t >= 188 && t <= 199) e.rst_out = 3'b000;
                else if (t >= 213 && t <= 216) e.rst_out = 3'b110;
                else if (t >= 217 && t <= 220) e.rst_out = 3'b100;
                else if (t >= 221)             e.rst_out = 3'b000;
            end
            2: begin
                // Flaky RAM lock: STABILIZE restarts at edge 20
                e.pll_rst = (t <= 3);
                if      (t >= 28 && t <= 31) e.rst_out = 3'b110;
                else if (t >= 32 && t <= 35) e.rst_out = 3'b100;
                else if (t >= 36)            e.rst_out = 3'b000;
            end
            default: begin
                // Locks held low: 36-cycle timeout period, count saturates
                k         = t / 36;
                e.pll_rst = (t % 36) < 4;
                e.tmo     = (k > 255) ? 8'd255 : 8'(k);
            end
        endcase
        e.all_up = (e.rst_out == 3'b000);
        return e;
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (e.cyc != cyc || bus.pll_rst !== e.pll_rst || bus.rst_out !== e.rst_out ||
                bus.all_up !== e.all_up || bus.relock_count !== e.relock ||
                bus.timeout_count !== e.tmo) begin
                miscompares++;
                $display("FAIL scen%0d t=%0d cyc=%0d/%0d: got pll_rst=%b rst_out=%b all_up=%b relock=%0d timeout=%0d, expected pll_rst=%b rst_out=%b all_up=%b relock=%0d timeout=%0d",
                         e.scen, e.t, cyc, e.cyc, bus.pll_rst, bus.rst_out, bus.all_up,
                         bus.relock_count, bus.timeout_count, e.pll_rst, e.rst_out,
                         e.all_up, e.relock, e.tmo);
            end
        end
    end

    // Wait so the next input change is sampled at edge e0+t.
    task automatic at_t(input int e0, input int t);
        while (cyc < e0 + t - 1) @(negedge clk);
    endtask

    task automatic begin_scen(input int scen, input int len, output int e0);
        @(negedge clk);
        rst               = 1'b1;
        bus.pll_main_lock = 1'b0;
        bus.pll_ram_lock  = 1'b0;
        @(negedge clk);
        e0 = cyc + 1;
        for (int t = 0; t <= len; t++) exp_q.push_back(mk(scen, e0, t));
        at_t(e0, 1);
        rst = 1'b0;
    endtask

    initial begin
        int e0;
        rst               = 1'b1;
        bus.pll_main_lock = 1'b0;
        bus.pll_ram_lock  = 1'b0;
        repeat (3) @(negedge clk);

        begin_scen(1, 230, e0);
        at_t(e0, 20);  bus.pll_main_lock = 1'b1; bus.pll_ram_lock = 1'b1;
        at_t(e0, 50);  bus.pll_main_lock = 1'b0;
        at_t(e0, 70);  bus.pll_main_lock = 1'b1;
        at_t(e0, 100); bus.pll_ram_lock  = 1'b0;
        at_t(e0, 110); bus.pll_ram_lock  = 1'b1;
        at_t(e0, 121); bus.pll_main_lock = 1'b0;
        at_t(e0, 170); bus.pll_main_lock = 1'b1;
        at_t(e0, 200); rst = 1'b1;
        at_t(e0, 201); rst = 1'b0;
        at_t(e0, 232);

        begin_scen(2, 45, e0);
        at_t(e0, 10); bus.pll_main_lock = 1'b1; bus.pll_ram_lock = 1'b1;
        at_t(e0, 15); bus.pll_ram_lock  = 1'b0;
        at_t(e0, 18); bus.pll_ram_lock  = 1'b1;
        at_t(e0, 47);

        begin_scen(3, 36 * 257, e0);
        at_t(e0, 36 * 257 + 2);

        repeat (10) begin
            if (exp_q.size() != 0) @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected vectors never checked, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
        $fatal(1);
    end

endmodule
